// File: rtl/cache_fill_fsm_pkg.sv
// Shared cache constants and fill-engine state encoding used by the miss
// handler and its counters.
package cache_fill_fsm_pkg;

  localparam int BLOCK_WORDS = 8;
  localparam int BLOCK_OFF_W = 3;
  localparam int BYTE_OFF_W  = 1;
  localparam int TAG_LSB     = BLOCK_OFF_W + BYTE_OFF_W;
  localparam int CNT_W       = BLOCK_OFF_W + 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } fill_state_t;

  // Mask keeping only the tag/index field [ADDR_W-1:TAG_LSB] of a byte address.
  function automatic logic [15:0] tagMask16();
    return {{(16 - TAG_LSB){1'b1}}, {TAG_LSB{1'b0}}};
  endfunction

endpackage

// File: rtl/cache_fill_fsm_counter.sv
// Saturating up-counter with synchronous clear and enable, used to track
// issued requests and accepted responses of one block fill.
module fill_counter
  import cache_fill_fsm_pkg::*;
#(
  parameter int W   = CNT_W,
  parameter int MAX = BLOCK_WORDS
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clear,
  input  logic         i_enable,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  // Holds at MAX so an over-eager enable can never wrap back to word zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && (r_count != W'(MAX))) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache miss fill engine: fetches one block from pipelined main memory, writes
// each returned word into the data array and the tag entry with the last word.
module cache_fill_fsm
  import cache_fill_fsm_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int WORDS  = BLOCK_WORDS,
  parameter int OFF_W  = BLOCK_OFF_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              miss_detected,
  input  logic [ADDR_W-1:0] miss_address,
  input  logic              mem_grant,
  input  logic              memory_data_valid,
  output logic              fsm_busy,
  output logic              read_req,
  output logic [ADDR_W-1:0] memory_address,
  output logic              write_data_array,
  output logic              write_tag_array,
  output logic [OFF_W-1:0]  fill_word
);

  localparam int LP_CNT_W   = OFF_W + 1;
  localparam int LP_TAG_LSB = OFF_W + BYTE_OFF_W;
  localparam logic [ADDR_W-1:0] LP_TAG_MASK =
    {{(ADDR_W - LP_TAG_LSB){1'b1}}, {LP_TAG_LSB{1'b0}}};

  fill_state_t         r_state;
  fill_state_t         w_nextState;
  logic [ADDR_W-1:0]   r_blockAddr;
  logic [LP_CNT_W-1:0] w_reqCnt;
  logic [LP_CNT_W-1:0] w_rspCnt;
  logic                w_start;
  logic                w_inFill;
  logic                w_issue;
  logic                w_accept;
  logic                w_lastWord;

  assign w_inFill   = (r_state == ST_FILL);
  assign w_start    = (r_state == ST_IDLE) && miss_detected;
  assign w_issue    = w_inFill && mem_grant && (w_reqCnt < LP_CNT_W'(WORDS));
  // Responses come back in request order, so only outstanding reads count.
  assign w_accept   = w_inFill && memory_data_valid && (w_rspCnt < w_reqCnt);
  assign w_lastWord = w_accept && (w_rspCnt == LP_CNT_W'(WORDS - 1));

  fill_counter #(.W(LP_CNT_W), .MAX(WORDS)) u_reqCounter (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clear  (w_start),
    .i_enable (w_issue),
    .o_count  (w_reqCnt)
  );

  fill_counter #(.W(LP_CNT_W), .MAX(WORDS)) u_rspCounter (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clear  (w_start),
    .i_enable (w_accept),
    .o_count  (w_rspCnt)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Block-aligned base keeps word offsets from ever carrying into the tag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_blockAddr <= '0;
    end else if (w_start) begin
      r_blockAddr <= miss_address & LP_TAG_MASK;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE: if (miss_detected) w_nextState = ST_FILL;
      ST_FILL: if (w_lastWord)    w_nextState = ST_IDLE;
      default: w_nextState = ST_IDLE;
    endcase
  end

  always_comb begin
    fsm_busy         = 1'b0;
    read_req         = 1'b0;
    memory_address   = '0;
    write_data_array = 1'b0;
    write_tag_array  = 1'b0;
    fill_word        = '0;
    case (r_state)
      ST_IDLE: begin
        fsm_busy = miss_detected;
      end
      ST_FILL: begin
        fsm_busy         = 1'b1;
        read_req         = w_issue;
        memory_address   = r_blockAddr |
                           {{(ADDR_W - OFF_W - 1){1'b0}}, w_reqCnt[OFF_W-1:0], 1'b0};
        write_data_array = w_accept;
        write_tag_array  = w_lastWord;
        fill_word        = w_accept ? w_rspCnt[OFF_W-1:0] : '0;
      end
      default: begin
        fsm_busy = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Directed bench for cache_fill_fsm with a 4-cycle pipelined memory model,
// a reference fill model and a scoreboard of expected word offsets.
module tb_cache_fill_fsm;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        miss_detected;
  logic [15:0] miss_address;
  logic        mem_grant;
  logic        memory_data_valid;
  logic        fsm_busy;
  logic        read_req;
  logic [15:0] memory_address;
  logic        write_data_array;
  logic        write_tag_array;
  logic [2:0]  fill_word;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          tagCycle = -1;
  int          tagCount = 0;
  int          writes = 0;

  logic [3:0]  memPipe = '0;
  logic        mFill = 1'b0;
  logic [11:0] mBase = '0;
  int          mReq = 0;
  int          mRsp = 0;
  logic        expReq = 1'b0;
  logic        expAcc = 1'b0;
  logic [2:0]  expQ[$];

  always #5 clk = ~clk;

  cache_fill_fsm dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .miss_detected     (miss_detected),
    .miss_address      (miss_address),
    .mem_grant         (mem_grant),
    .memory_data_valid (memory_data_valid),
    .fsm_busy          (fsm_busy),
    .read_req          (read_req),
    .memory_address    (memory_address),
    .write_data_array  (write_data_array),
    .write_tag_array   (write_tag_array),
    .fill_word         (fill_word)
  );

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s cycle=%0d observed=0x%0h expected=0x%0h", tag, cyc, obs, exp);
    end
  endtask

  // Drives one cycle of inputs; memory returns data 4 cycles after each request.
  task automatic applyStimulus(input logic miss, input logic [15:0] addr, input logic grant,
                               input logic rstn, input logic stray);
    @(posedge clk);
    #1;
    rst_n             = rstn;
    miss_detected     = miss;
    miss_address      = addr;
    mem_grant         = grant;
    memory_data_valid = memPipe[3] | stray;
    expReq = mFill && grant && (mReq < 8);
    expAcc = mFill && memory_data_valid && (mRsp < mReq);
  endtask

  task automatic checkOutput();
    logic [2:0] w;
    @(negedge clk);
    checkVal("fsm_busy", fsm_busy, mFill ? 1'b1 : miss_detected);
    checkVal("read_req", read_req, expReq);
    if (mFill) checkVal("memory_address", memory_address, {mBase, 3'(mReq), 1'b0});
    checkVal("write_data_array", write_data_array, expAcc);
    checkVal("write_tag_array", write_tag_array, expAcc && (mRsp == 7));
    if (write_data_array) begin
      checkVal("scoreboard_pending", expQ.size() > 0, 1'b1);
      if (expQ.size() > 0) begin
        w = expQ.pop_front();
        checkVal("fill_word", fill_word, w);
        checkVal("tag_on_last_word", write_tag_array, w == 3'd7);
      end
      writes++;
    end
    if (write_tag_array) begin
      tagCycle = cyc;
      tagCount++;
    end
    memPipe = {memPipe[2:0], expReq};
    if (!rst_n) begin
      mFill = 1'b0; mReq = 0; mRsp = 0; mBase = '0;
      expQ.delete();
    end else if (!mFill) begin
      if (miss_detected) begin
        mFill = 1'b1; mBase = miss_address[15:4]; mReq = 0; mRsp = 0;
      end
    end else begin
      if (expReq) begin
        expQ.push_back(3'(mReq));
        mReq++;
      end
      if (expAcc) begin
        if (mRsp == 7) mFill = 1'b0;
        mRsp++;
      end
    end
    cyc++;
  endtask

  task automatic runCycle(input logic miss, input logic [15:0] addr, input logic grant,
                          input logic rstn, input logic stray);
    applyStimulus(miss, addr, grant, rstn, stray);
    checkOutput();
  endtask

  task automatic startScenario();
    cyc = 0; tagCycle = -1; tagCount = 0; writes = 0;
  endtask

  initial begin
    rst_n = 1'b0; miss_detected = 1'b0; miss_address = '0;
    mem_grant = 1'b0; memory_data_valid = 1'b0;

    runCycle(0, 16'h0000, 0, 0, 0);
    runCycle(0, 16'h0000, 0, 0, 0);
    checkVal("reset_memory_address", memory_address, 16'h0000);
    checkVal("reset_fill_word", fill_word, 3'd0);
    runCycle(0, 16'h0000, 1, 1, 0);

    $display("[TB] basic fill at 0x1234");
    startScenario();
    runCycle(1, 16'h1234, 1, 1, 0);
    for (int i = 1; i <= 14; i++) runCycle(0, 16'h0000, 1, 1, 0);
    checkVal("basic_tag_cycle", tagCycle, 12);
    checkVal("basic_words", writes, 8);
    checkVal("basic_drained", expQ.size(), 0);

    $display("[TB] grant withheld cycles 3-5");
    startScenario();
    runCycle(1, 16'h1234, 1, 1, 0);
    for (int i = 1; i <= 18; i++) runCycle(0, 16'h0000, !(i >= 3 && i <= 5), 1, 0);
    checkVal("grant_tag_cycle", tagCycle, 15);
    checkVal("grant_words", writes, 8);

    $display("[TB] stray data in IDLE and early FILL");
    startScenario();
    runCycle(0, 16'h0000, 1, 1, 1);
    runCycle(0, 16'h0000, 1, 1, 1);
    startScenario();
    runCycle(1, 16'h2000, 1, 1, 0);
    runCycle(0, 16'h0000, 0, 1, 1);
    runCycle(0, 16'h0000, 1, 1, 1);
    checkVal("stray_no_write", writes, 0);
    for (int i = 3; i <= 16; i++) runCycle(0, 16'h0000, 1, 1, 0);
    checkVal("stray_tag_cycle", tagCycle, 13);
    checkVal("stray_words", writes, 8);

    $display("[TB] reset in cycle 6 of a fill");
    startScenario();
    runCycle(1, 16'h4560, 1, 1, 0);
    for (int i = 1; i <= 5; i++) runCycle(0, 16'h0000, 1, 1, 0);
    runCycle(0, 16'h0000, 1, 0, 0);
    runCycle(0, 16'h0000, 1, 1, 0);
    checkVal("abort_busy", fsm_busy, 1'b0);
    for (int i = 8; i <= 12; i++) runCycle(0, 16'h0000, 1, 1, 1);
    checkVal("abort_words", writes, 2);
    checkVal("abort_no_tag", tagCount, 0);
    for (int i = 0; i < 3; i++) runCycle(0, 16'h0000, 1, 1, 0);

    $display("[TB] back-to-back misses at 0xFFF0 then 0x0000");
    startScenario();
    runCycle(1, 16'hFFF0, 1, 1, 0);
    for (int i = 1; i <= 11; i++) runCycle(0, 16'h0000, 1, 1, 0);
    runCycle(1, 16'h0000, 1, 1, 0);
    runCycle(1, 16'h0000, 1, 1, 0);
    for (int i = 14; i <= 27; i++) runCycle(0, 16'h0000, 1, 1, 0);
    checkVal("b2b_tag_count", tagCount, 2);
    checkVal("b2b_last_tag_cycle", tagCycle, 25);
    checkVal("b2b_words", writes, 16);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
